// File: rtl/onehot_pkg.sv
// Shared types and defaults for the request index serializer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package onehot_pkg;

  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = 3;

  // Two live codes; the other two are unreachable and recover to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1
  } state_t;

endpackage

// File: rtl/req_index_serializer_if.sv
// Handshake bundle between vector producer, serializer and index consumer.
// Latency: none (wiring only).
// Backpressure: in_ready gates capture, out_ready gates each index beat.
interface req_index_serializer_if #(
  parameter int N = onehot_pkg::N_DEF
);
  localparam int IDX_W = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             zero_drop;

  // Environment side: drives vectors, consumes indices.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero_drop
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero_drop
  );

endinterface

// File: rtl/first_set_index.sv
// Index of the lowest (or highest, MSB_FIRST=1) set bit, plus an exactly-one-bit flag.
// Latency: combinational.
// Backpressure: not applicable.
module first_set_index
  import onehot_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic [N-1:0]     pending,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;

  // Later loop iterations overwrite earlier ones, so scan direction picks the winner.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) lo_idx = IDX_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (pending[i]) hi_idx = IDX_W'(i);
    end
  end

  assign idx    = MSB_FIRST ? hi_idx : lo_idx;
  assign single = (pending != '0) && ((pending & (pending - N'(1))) == '0);

endmodule

// File: rtl/req_index_serializer.sv
// Serializes a multi-hot request vector into one bit index per handshake; REQ_SER_MSB_FIRST_EN selects descending order.
// Latency: 1 cycle capture-to-first-index, then one index per cycle with out_ready high.
// Backpressure: in_ready only in IDLE; out_idx/out_last hold while out_valid && !out_ready.
module req_index_serializer
  import onehot_pkg::*;
#(
  parameter int N      = N_DEF,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  req_index_serializer_if.slave  bus
);

`ifdef REQ_SER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [N-1:0]     pending_q;
  logic [N-1:0]     pending_d;
  logic             zero_drop_q;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_single;

  first_set_index #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_first_set_index (
    .pending (pending_q),
    .idx     (sel_idx),
    .single  (sel_single)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_drop_q <= (state_q == IDLE) && bus.in_valid && (bus.in_vec == '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && (bus.in_vec != '0)) begin
          pending_d = bus.in_vec;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pending_d = pending_q & ~(N'(1) << sel_idx);
          if (sel_single) state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // pending is empty whenever IDLE, so out_idx reads 0 outside EMIT.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_idx   = sel_idx;
  assign bus.out_last  = sel_single && (state_q == EMIT);
  assign bus.zero_drop = zero_drop_q;

endmodule

// File: tb/tb_req_index_serializer.sv
// Randomized and directed bench for req_index_serializer against a queue-based reference model.
// Honours REQ_SER_MSB_FIRST_EN for the expected emission order.
module tb_req_index_serializer;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  req_index_serializer_if #(.N(N)) bus ();

  req_index_serializer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Expected index sequence: every set bit exactly once, in the configured order.
  task automatic model(input logic [N-1:0] vec, output int q[$]);
    q = {};
`ifdef REQ_SER_MSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) if (vec[i]) q.push_back(i);
`else
    for (int i = 0; i < N; i++) if (vec[i]) q.push_back(i);
`endif
  endtask

  // Entered and left at posedge+1.
  task automatic send(input logic [N-1:0] vec, input int stall_first, input int stall_pct);
    int q[$];
    int cycles;
    int stalls;
    int k;
    model(vec, q);
    k = q.size();
    check("in_ready_before_capture", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = vec;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (k == 0) begin
      @(negedge clk);
      check("zero_drop_pulse", bus.zero_drop, 1);
      check("zero_out_valid", bus.out_valid, 0);
      check("zero_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("zero_drop_one_cycle", bus.zero_drop, 0);
      check("zero_out_valid_after", bus.out_valid, 0);
      @(posedge clk); #1;
      return;
    end
    cycles = 0;
    stalls = 0;
    while (q.size() > 0 && cycles < 200) begin
      // Inputs seen during EMIT must have no effect.
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_vec   = N'($urandom);
      bus.out_ready = (cycles >= stall_first) && ($urandom_range(0, 99) >= stall_pct);
      if (!bus.out_ready) stalls++;
      @(negedge clk);
      check("out_valid", bus.out_valid, 1);
      check("in_ready_busy", bus.in_ready, 0);
      check("out_idx", bus.out_idx, q[0]);
      check("out_last", bus.out_last, (q.size() == 1));
      if (bus.out_ready) void'(q.pop_front());
      @(posedge clk); #1;
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (cycles >= 200) check("emit_timeout", 0, 1);
    check("emit_cycles", cycles, k + stalls);
    @(negedge clk);
    check("in_ready_after_last", bus.in_ready, 1);
    check("out_valid_after_last", bus.out_valid, 0);
    check("out_idx_idle", bus.out_idx, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_zero_drop", bus.zero_drop, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send(8'b1010_0100, 0, 0);
    send(8'h81, 3, 0);
    send(8'hFF, 0, 0);
    send(8'h00, 0, 0);

    // Reset in the middle of an emission: remaining indices are dropped.
    begin
      int q[$];
      model(8'hF0, q);
      bus.in_valid = 1'b1;
      bus.in_vec   = 8'hF0;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_first_idx", bus.out_idx, q[0]);
      check("rst_mid_first_valid", bus.out_valid, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_mid_out_valid_async", bus.out_valid, 0);
      check("rst_mid_in_ready_async", bus.in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("rst_mid_no_more_beats", bus.out_valid, 0);
        check("rst_mid_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
      end
      send(8'h02, 0, 0);
    end

    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] v;
      v = (t % 8 == 7) ? '0 : N'($urandom);
      send(v, $urandom_range(0, 2), $urandom_range(0, 50));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/req_index_serializer.md
# req_index_serializer

Turns a multi-hot request vector into a stream of bit indices, one per handshake. It is the sequential inverse of the 3-to-8 one-hot decode path: each index it emits, decoded back to one-hot, gives exactly one set bit of the captured vector. It sits between request-collection logic and any consumer that handles one indexed request at a time.

## Interface
- N, default 8: request vector width; power of two, at least 2.
- IDX_W, default $clog2(N) = 3: index width; derived, never overridden.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a vector; high only in IDLE.
- in_vec  in  N  request vector; any number of bits set.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts out_idx.
- out_idx  out  IDX_W  index of the current set bit.
- out_last  out  1  out_idx is the final set bit of the captured vector.
- zero_drop  out  1  one-cycle pulse when an all-zero vector was accepted.

## Operation
- Two-state FSM: IDLE and EMIT. The 2-bit state encoding leaves the remaining codes unreachable; they recover to IDLE.
- Reset: state=IDLE, pending=0, zero_drop=0. This gives in_ready=1, out_valid=0, out_idx=0 and out_last=0.
- in_ready = (state==IDLE). out_valid = (state==EMIT).
- IDLE, in_valid=1, in_vec!=0: pending<=in_vec, go to EMIT.
- IDLE, in_valid=1, in_vec==0: the vector is consumed. zero_drop=1 for the next cycle; state stays IDLE.
- EMIT behaviour:
  - out_idx = index of the lowest set bit of pending (default order).
  - out_last = 1 when pending has exactly one bit set.
  - On out_valid && out_ready: clear that bit in pending. If out_last=1, go to IDLE.
- Hold rule: while out_valid=1 and out_ready=0, out_idx and out_last hold stable.
- in_vec and in_valid are ignored in EMIT. There is no overlap between the last beat and the next capture.
- Each emitted index appears exactly once. Indices come out in strictly ascending order.
- out_idx and out_last are functions of registered state only. They have no combinational path from any input.

## Timing
- Capture to first out_valid: 1 cycle.
- Throughput with out_ready held high: one index per cycle.
- A vector with k set bits takes 1 capture cycle plus k emit cycles. The next capture is possible on the cycle after the last beat.
- zero_drop is asserted in the cycle after the capture edge, for exactly one cycle.
- rst asserted mid-EMIT: out_valid drops immediately (asynchronous) and the remaining indices are discarded. On release, the block is in IDLE with in_ready=1.
- Simultaneous rst and a handshake: rst wins and nothing is emitted.

## Configuration
- REQ_SER_MSB_FIRST_EN
  - Defined: out_idx selects the highest set bit of pending, so indices come out in strictly descending order. out_last still marks the single remaining bit.
  - Undefined: lowest set bit first (ascending order).
  - All other behaviour and timing are identical.

## Structure
- Package onehot_pkg holds:
  - typedef enum for the FSM states IDLE and EMIT;
  - default constants N_DEF=8 and IDX_W_DEF=3.
- Sub-module first_set_index is combinational. Parameters: N, and a direction bit set from REQ_SER_MSB_FIRST_EN. Inputs: pending. Outputs: idx and single (exactly one bit set).
- The top holds the FSM, the pending register, the zero_drop flop and the handshake logic.

## Test plan
- Ascending order: in_vec=8'b1010_0100, out_ready=1. Expect out_idx 2, 5, 7 on consecutive cycles, out_last=1 only with 7, and in_ready=1 on the following cycle.
- Backpressure: in_vec=8'h81, out_ready=0 for 3 cycles then 1. Expect out_idx=0 held for 3 cycles with out_last=0, then beats 0 and 7, out_last=1 on 7.
- Full vector: in_vec=8'hFF. Expect 8 beats with indices 0..7, out_last only on 7, 9 cycles from capture to in_ready.
- Zero vector: in_vec=8'h00 with in_valid=1. Expect a zero_drop pulse one cycle wide, out_valid never asserted, in_ready remaining 1.
- Reset mid-operation: in_vec=8'hF0. After beat idx=4 completes, pulse rst. Expect out_valid=0 at once and no idx 5/6/7. After release, a new in_vec=8'h02 produces a single beat idx=1 with out_last=1.
- Macro defined: in_vec=8'b1010_0100. Expect out_idx 7, 5, 2, with out_last on 2.
